// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for one serial/parallel multiplier (spm) datapath.
// Holds the multiplicand on spm.x. Streams the sign-extended multiplier
// LSB-first into spm.y and shifts the serial product from spm.p into a
// 2*size-bit result, which is returned over a valid/ready handshake.
module spm_ctrl #(
    parameter int unsigned size = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [size-1:0]   mc,
    input  logic [size-1:0]   mp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*size-1:0] prod,
    output logic              busy,
    output logic              spm_rst,
    output logic [size-1:0]   spm_x,
    output logic              spm_y,
    input  logic              spm_p
);

    localparam int unsigned CntW = $clog2(2 * size + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(2 * size);
    localparam logic [CntW-1:0] CntSize = CntW'(size);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [size-1:0]   mp_q, mp_d;
    logic [size-1:0]   x_q, x_d;
    logic              y_q, y_d;
    logic              srst_q, srst_d;
    logic [2*size-1:0] prod_q, prod_d;
    logic [size-1:0]   mp_shr;

    // Next-state, counter, serial-bit and product-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mp_d    = mp_q;
        x_d     = x_q;
        y_d     = 1'b0;
        prod_d  = prod_q;
        mp_shr  = '0;

        if (abort) begin
            // Flush wins over everything, including a same-cycle in_valid.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_d     = mc;
                        mp_d    = mp;
                        cnt_d   = '0;
                        // First serial bit must be on spm.y during cnt=0.
                        y_d     = mp[0];
                        state_d = StRun;
                    end
                end
                StRun: begin
                    // spm.p carries product bit k while cnt=k+1.
                    if (cnt_q != '0) begin
                        prod_d = {spm_p, prod_q[2*size-1:1]};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end else if (cnt_d < CntSize) begin
                        mp_shr = mp_q >> cnt_d;
                        y_d    = mp_shr[0];
                    end else if (cnt_d < CntLast) begin
                        // Sign extension of the multiplier.
                        y_d = mp_q[size-1];
                    end else begin
                        y_d = 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Datapath is held cleared whenever the next state is not RUN.
        srst_d = (state_d != StRun);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mp_q    <= '0;
            x_q     <= '0;
            y_q     <= 1'b0;
            srst_q  <= 1'b1;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mp_q    <= mp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            srst_q  <= srst_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign prod      = prod_q;
    assign spm_rst   = srst_q;
    assign spm_x     = x_q;
    assign spm_y     = y_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Self-checking bench for spm_ctrl (size=32) with a behavioural spm model.
module tb_spm_ctrl;

    localparam int unsigned Size = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [Size-1:0] mc = '0;
    logic [Size-1:0] mp = '0;
    logic            in_ready;
    logic            out_valid;
    logic [2*Size-1:0] prod;
    logic            busy;
    logic            spm_rst;
    logic [Size-1:0] spm_x;
    logic            spm_y;
    logic            spm_p;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    spm_ctrl #(.size(Size)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mc        (mc),
        .mp        (mp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy),
        .spm_rst   (spm_rst),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p)
    );

    always #5 clk = ~clk;

    // Behavioural spm: registered p = bit i of x * (y bits received so far).
    logic [63:0] m_ycol, ycol_n, full_n;
    int          m_i;
    logic        m_p;

    always_comb begin
        ycol_n = m_ycol;
        if (m_i < 64) ycol_n = m_ycol | (64'(spm_y) << m_i);
        full_n = {{32{spm_x[31]}}, spm_x} * ycol_n;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || spm_rst) begin
            m_ycol <= '0;
            m_i    <= 0;
            m_p    <= 1'b0;
        end else begin
            m_ycol <= ycol_n;
            m_p    <= (m_i < 64) ? full_n[m_i[5:0]] : 1'b0;
            m_i    <= m_i + 1;
        end
    end

    assign spm_p = m_p;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("invariant", 64'((in_ready && busy) || (out_valid && !busy) ||
                                   (in_ready && out_valid)), 64'd0);
        end
    end

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int gap, input int hold);
        logic [63:0] exp;
        int          lat;
        exp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        repeat (gap) step();
        lat = 0;
        while (!in_ready && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        mc = a;
        mp = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd66);
        check({tag, "_prod"}, prod, exp);
        repeat (hold) step();
        check({tag, "_held"}, 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int w;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_spm_rst", 64'(spm_rst), 64'd1);
        check("rst_spm_x", 64'(spm_x), 64'd0);
        check("rst_spm_y", 64'(spm_y), 64'd0);
        check("rst_prod", prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // Directed operand patterns
        run_op("m50", 32'd50, 32'hFFFF_FFCE, 0, 0);
        check("m50_value", prod, 64'hFFFF_FFFF_FFFF_F63C);
        run_op("neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("neg1_value", prod, 64'h1);
        run_op("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0);
        check("maxpos_value", prod, 64'h3FFF_FFFF_0000_0001);
        run_op("minneg", 32'h8000_0000, 32'h8000_0000, 0, 2);
        check("minneg_value", prod, 64'h4000_0000_0000_0000);
        run_op("zero", 32'h0, 32'h8000_0000, 0, 0);
        check("zero_value", prod, 64'h0);

        // Backpressure in DONE with a concurrent in_valid
        mc = 32'd1234;
        mp = 32'd5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 200) begin
            step();
            w++;
        end
        mc = 32'd99;
        mp = 32'd99;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_prod", prod, 64'd7006652);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle", 64'(in_ready), 64'd1);
        check("bp_ignored", 64'(spm_x), 64'd1234);

        // Abort at cnt=10 with a concurrent in_valid
        mc = 32'd5;
        mp = 32'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        check("ab_busy", 64'(busy), 64'd1);
        check("ab_spm_rst_run", 64'(spm_rst), 64'd0);
        abort = 1'b1;
        in_valid = 1'b1;
        mc = 32'd77;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        check("ab_in_ready", 64'(in_ready), 64'd1);
        check("ab_spm_rst", 64'(spm_rst), 64'd1);
        check("ab_out_valid", 64'(out_valid), 64'd0);
        check("ab_busy_after", 64'(busy), 64'd0);
        // Abort in IDLE blocks a same-cycle in_valid
        abort = 1'b1;
        in_valid = 1'b1;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        check("ab_idle_busy", 64'(busy), 64'd0);
        run_op("after_abort", 32'd3, 32'hFFFF_FFF9, 0, 0);
        check("after_abort_value", prod, 64'hFFFF_FFFF_FFFF_FFEB);

        // Asynchronous reset mid-RUN, between clock edges
        mc = 32'h1234_5678;
        mp = 32'h0BAD_F00D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        check("ar_spm_rst", 64'(spm_rst), 64'd1);
        check("ar_spm_x", 64'(spm_x), 64'd0);
        check("ar_spm_y", 64'(spm_y), 64'd0);
        check("ar_prod", prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op("after_rst", 32'hFFFF_FC18, 32'd4097, 0, 0);
        check("after_rst_value", prod, 64'hFFFF_FFFF_FFC1_7C18);

        // Random signed operands with random gaps and backpressure
        for (int i = 0; i < 300; i++) begin
            run_op("rand", $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
